frame_encoder: RTL and testbench
================================

// Module: frame_encoder
// PURPOSE
//  Tx-direction frame encoder: turns an Axi4-Stream frame (tdata/tlast) into a framed, escaped byte stream.
//  Emits START_BYTE, payload with ESCAPE_BYTE before any reserved byte, then STOP_BYTE after the tlast byte.
//  Single-module counterpart of the rx deframe/de-escape path. Sits between the tx packet source and the UART/byte sink.
// PARAMETERS
//  ESCAPE_BYTE  8'h7F  escape marker; prefixed to any payload byte equal to ESCAPE/START/STOP_BYTE
//  START_BYTE   8'h7D  frame start marker
//  STOP_BYTE    8'h7E  frame stop marker
//  CNT_W        16     width of frame_count
// PORTS
//  aclk              in   1      clock
//  areset            in   1      synchronous reset, active-high
//  target_tvalid     in   1      frame payload valid
//  target_tready     out  1      frame payload accepted
//  target_tdata      in   8      payload byte
//  target_tlast      in   1      last payload byte of frame
//  initiator_tvalid  out  1      encoded byte valid (registered)
//  initiator_tready  in   1      byte sink ready
//  initiator_tdata   out  8      encoded byte (registered)
//  frame_done        out  1      1-cycle pulse on STOP_BYTE handshake (registered)
//  frame_count       out  CNT_W  frames completed since reset, wraps at 2**CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset: initiator_tvalid=0, initiator_tdata=8'h00, frame_done=0, frame_count=0, state=S_IDLE; target_tready=0 while areset=1.
//  - Output register: slot_free = !initiator_tvalid | initiator_tready. Loaded only when slot_free; else tdata/tvalid held stable.
//    If slot_free and nothing to load, initiator_tvalid drops to 0 next cycle.
//  - reserved(b) = (b==ESCAPE_BYTE)|(b==START_BYTE)|(b==STOP_BYTE).
//  - FSM (evaluated only when slot_free; otherwise state holds, target_tready=0):
//    S_IDLE : target_tvalid -> load START_BYTE, input NOT consumed, -> S_DATA.
//    S_DATA : target_tvalid & reserved(tdata) -> load ESCAPE_BYTE, NOT consumed, -> S_ESC.
//             target_tvalid & !reserved -> load tdata, consume; -> S_STOP if tlast else S_DATA.
//    S_ESC  : load held tdata, consume; -> S_STOP if tlast else S_DATA (target_tvalid guaranteed high: input unconsumed).
//    S_STOP : load STOP_BYTE, -> S_IDLE.
//  - target_tready = !areset & slot_free & target_tvalid & ((S_DATA & !reserved(tdata)) | S_ESC); combinational, no input buffering.
//  - Source must hold tdata/tlast stable while tvalid & !tready (Axi4-Stream rule); S_ESC relies on it.
//  - Latency: START_BYTE valid 1 cycle after first target_tvalid in S_IDLE. Full rate with initiator_tready=1:
//    one output byte per cycle, no bubbles inside a frame or between back-to-back frames (S_IDLE loads START in the
//    cycle STOP handshakes).
//  - Zero-length frames are impossible: every frame carries >=1 payload byte (tlast byte itself).
//  - frame_done/frame_count update on the cycle after STOP_BYTE handshake (initiator_tvalid & tready & data==STOP in S_IDLE-bound slot).
//  - Reset mid-frame: partial frame abandoned, no STOP emitted, initiator_tvalid=0 next cycle; following frame starts with START_BYTE.
//  - Payload byte equal to a marker never appears on initiator_tdata unless directly preceded by ESCAPE_BYTE.
// TESTING
//  1. Frame [01 02 03], tlast on 03, tready=1 -> 7D 01 02 03 7E on 5 consecutive cycles; frame_done pulse once; frame_count 0->1.
//  2. Frame [7D 7E 7F] -> 7D 7F 7D 7F 7E 7F 7F 7E; target_tready low on each escape cycle.
//  3. Single-byte frame [7F] tlast -> 7D 7F 7F 7E; escape on tlast byte still ends with STOP.
//  4. Frames [AA],[BB] back-to-back, tready=1 -> 7D AA 7E 7D BB 7E with no idle cycle; frame_count=2.
//  5. Frame [10 7E 20] with random 50% initiator_tready -> same byte sequence as unstalled; tdata stable while tvalid & !tready.
//  6. Assert areset after 2 output beats of [01 02 03 04] -> next cycle tvalid=0, tready=0, frame_count=0; next frame [55] -> 7D 55 7E.

Source files
------------

// File: rtl/frame_encoder.sv
// Tx frame encoder: wraps an AXI4-Stream byte frame in START/STOP markers and
// escapes any payload byte that collides with a marker value.
module frame_encoder #(
  parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
  parameter logic [7:0] START_BYTE  = 8'h7D,
  parameter logic [7:0] STOP_BYTE   = 8'h7E,
  parameter int         CNT_W       = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             target_tvalid,
  output logic             target_tready,
  input  logic [7:0]       target_tdata,
  input  logic             target_tlast,
  output logic             initiator_tvalid,
  input  logic             initiator_tready,
  output logic [7:0]       initiator_tdata,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count
);

  // Handshake rule on both sides: a beat transfers on the rising clock edge
  // where tvalid and tready are both high; a valid beat is held until taken.

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ESC, S_STOP} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             out_is_stop_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] frame_count_q;

  logic       slot_free;
  logic       reserved;
  logic       load;
  logic       load_stop;
  logic       consume;
  logic [7:0] load_data;
  logic       stop_hs;

  assign slot_free = !out_valid_q || initiator_tready;
  assign reserved  = (target_tdata == ESCAPE_BYTE) || (target_tdata == START_BYTE) ||
                     (target_tdata == STOP_BYTE);
  // A data byte equal to STOP_BYTE may be on the wire too, so frame end is
  // tracked by a flag rather than by comparing the output byte.
  assign stop_hs   = out_valid_q && initiator_tready && out_is_stop_q;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_stop = 1'b0;
    consume   = 1'b0;
    load_data = 8'h00;
    if (slot_free) begin
      unique case (state_q)
        S_IDLE: begin
          if (target_tvalid) begin
            load      = 1'b1;
            load_data = START_BYTE;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (target_tvalid) begin
            load = 1'b1;
            if (reserved) begin
              load_data = ESCAPE_BYTE;
              state_d   = S_ESC;
            end else begin
              load_data = target_tdata;
              consume   = 1'b1;
              state_d   = target_tlast ? S_STOP : S_DATA;
            end
          end
        end
        S_ESC: begin
          // The escaped byte is still held on the input, unconsumed.
          load      = 1'b1;
          load_data = target_tdata;
          consume   = target_tvalid;
          state_d   = target_tlast ? S_STOP : S_DATA;
        end
        S_STOP: begin
          load      = 1'b1;
          load_stop = 1'b1;
          load_data = STOP_BYTE;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      out_is_stop_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= stop_hs;
      if (stop_hs) frame_count_q <= frame_count_q + CNT_W'(1);
      if (slot_free) begin
        out_valid_q   <= load;
        out_is_stop_q <= load_stop;
        if (load) out_data_q <= load_data;
      end
    end
  end

  assign target_tready    = !areset && consume;
  assign initiator_tvalid = out_valid_q;
  assign initiator_tdata  = out_data_q;
  assign frame_done       = frame_done_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_frame_encoder.sv
// Directed bench for frame_encoder: table of frames with expected encoded
// byte streams, plus hand-written stall and mid-frame reset sequences.
module tb_frame_encoder;

  logic        aclk = 1'b0;
  logic        areset;
  logic        target_tvalid;
  logic        target_tready;
  logic [7:0]  target_tdata;
  logic        target_tlast;
  logic        initiator_tvalid;
  logic        initiator_tready;
  logic [7:0]  initiator_tdata;
  logic        frame_done;
  logic [15:0] frame_count;

  frame_encoder dut (
    .aclk             (aclk),
    .areset           (areset),
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .target_tlast     (target_tlast),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata),
    .frame_done       (frame_done),
    .frame_count      (frame_count)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  bit stall_en = 1'b0;

  always @(posedge aclk) begin
    #1;
    initiator_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         in_hs    = 0;
  int         done_cnt = 0;
  bit         hold_pend = 1'b0;
  logic [7:0] hold_data;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Everything is observed at the falling edge, midway between active edges.
  always @(negedge aclk) begin
    if (hold_pend && !areset) begin
      n_cmp++;
      if (!(initiator_tvalid === 1'b1 && initiator_tdata === hold_data)) begin
        n_fail++;
        $display("FAIL hold_stable: got valid=%0b data=%0h expected valid=1 data=%0h",
                 initiator_tvalid, initiator_tdata, hold_data);
      end
    end
    hold_pend = initiator_tvalid && !initiator_tready && !areset;
    hold_data = initiator_tdata;
    if (initiator_tvalid && initiator_tready) begin
      got_q.push_back(initiator_tdata);
      got_cyc.push_back(cyc);
    end
    if (target_tvalid && target_tready) in_hs++;
    if (frame_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    areset        = 1'b1;
    target_tvalid = 1'b1;
    target_tdata  = 8'h01;
    target_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", initiator_tvalid, 0);
    check("rst_tdata", initiator_tdata, 8'h00);
    check("rst_done", frame_done, 0);
    check("rst_count", frame_count, 0);
    check("rst_tready", target_tready, 0);
    target_tvalid = 1'b0;
    areset        = 1'b0;
    @(posedge aclk);
    #1;
    got_q.delete();
    got_cyc.delete();
    in_hs    = 0;
    done_cnt = 0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic last);
    int  waited;
    bit  hs;
    target_tvalid = 1'b1;
    target_tdata  = b;
    target_tlast  = last;
    waited = 0;
    do begin
      @(negedge aclk);
      hs = target_tready;
      @(posedge aclk);
      #1;
      waited++;
    end while (!hs && waited < 200);
    if (!hs) check("drive_timeout", 0, 1);
  endtask

  task automatic wait_output(input int n);
    int waited = 0;
    while (got_q.size() < n && waited < 400) begin
      @(posedge aclk);
      #1;
      waited++;
    end
    if (got_q.size() < n) check("out_timeout", got_q.size(), n);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] in_w;       // payload bytes, first byte in [31:24]
    int          n_in;
    logic [3:0]  last_mask;  // bit i set -> byte i carries tlast
    logic [63:0] exp_w;      // encoded bytes, first byte in [63:56]
    int          n_exp;
    int          n_frames;
    bit          stall;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int start_cyc;
    vecs[0] = '{32'h010203_00, 3, 4'b0100, 64'h7D_01_02_03_7E_000000, 5, 1, 1'b0};
    vecs[1] = '{32'h7D7E7F_00, 3, 4'b0100, 64'h7D_7F_7D_7F_7E_7F_7F_7E, 8, 1, 1'b0};
    vecs[2] = '{32'h7F_000000, 1, 4'b0001, 64'h7D_7F_7F_7E_00000000, 4, 1, 1'b0};
    vecs[3] = '{32'hAABB_0000, 2, 4'b0011, 64'h7D_AA_7E_7D_BB_7E_0000, 6, 2, 1'b0};
    vecs[4] = '{32'h107E20_00, 3, 4'b0100, 64'h7D_10_7F_7E_20_7E_0000, 6, 1, 1'b1};

    areset           = 1'b1;
    target_tvalid    = 1'b0;
    target_tdata     = 8'h00;
    target_tlast     = 1'b0;
    initiator_tready = 1'b1;

    for (int v = 0; v < 5; v++) begin
      stall_en = 1'b0;
      do_reset();
      stall_en = vecs[v].stall;
      exp_q.delete();
      for (int i = 0; i < vecs[v].n_exp; i++) exp_q.push_back(vecs[v].exp_w[63 - 8*i -: 8]);
      start_cyc = cyc;
      for (int i = 0; i < vecs[v].n_in; i++)
        drive_byte(vecs[v].in_w[31 - 8*i -: 8], vecs[v].last_mask[i]);
      target_tvalid = 1'b0;
      target_tlast  = 1'b0;
      wait_output(vecs[v].n_exp);
      compare_stream($sformatf("v%0d", v));
      check($sformatf("v%0d_in_hs", v), in_hs, vecs[v].n_in);
      check($sformatf("v%0d_done", v), done_cnt, vecs[v].n_frames);
      check($sformatf("v%0d_count", v), frame_count, vecs[v].n_frames);
      if (!vecs[v].stall && got_q.size() == vecs[v].n_exp) begin
        check($sformatf("v%0d_latency", v), got_cyc[0], start_cyc + 1);
        check($sformatf("v%0d_span", v), got_cyc[vecs[v].n_exp-1] - got_cyc[0], vecs[v].n_exp - 1);
      end
    end

    // Mid-frame reset after two output beats; frame_count is 1 from the previous frame.
    stall_en = 1'b0;
    @(posedge aclk);
    #1;
    target_tvalid = 1'b1;
    target_tdata  = 8'h01;
    target_tlast  = 1'b0;
    @(posedge aclk);  // START loaded
    #1;
    @(posedge aclk);  // 01 consumed and loaded
    #1;
    target_tdata = 8'h02;
    areset       = 1'b1;
    #1;
    check("mid_rst_tready_in", target_tready, 0);
    @(posedge aclk);
    #1;
    target_tvalid = 1'b0;
    check("mid_rst_tvalid", initiator_tvalid, 0);
    check("mid_rst_tready", target_tready, 0);
    check("mid_rst_count", frame_count, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    got_q.delete();
    got_cyc.delete();
    done_cnt = 0;
    exp_q.delete();
    exp_q.push_back(8'h7D);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h7E);
    drive_byte(8'h55, 1'b1);
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
    wait_output(3);
    compare_stream("post_rst");
    check("post_rst_count", frame_count, 1);
    check("post_rst_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
